// File: rtl/i2s_audio_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_audio_in
// Purpose  : I2S slave receiver. Synchronises an external bclk/lrclk/data
//            triple into clk, frames left/right slots (1-bit I2S delay),
//            tracks lock and hands signed stereo frames to the mixer over a
//            valid/ready handshake with an overrun strobe.
// Revision : 1.0  initial release
// ============================================================================
module i2s_audio_in #(
    parameter int AUDIO_DW    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i2s_bclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_data,
    output logic [AUDIO_DW-1:0] left_out,
    output logic [AUDIO_DW-1:0] right_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                locked,
    output logic                overrun
);

    localparam int CNT_W = $clog2(AUDIO_DW + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_slot_bits = CNT_W'(AUDIO_DW);
    localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(AUDIO_DW - 1);
    localparam logic [TO_W-1:0]  c_timeout   = TO_W'(TIMEOUT);

    localparam logic [1:0] c_st_unlocked = 2'd0;
    localparam logic [1:0] c_st_sync     = 2'd1;
    localparam logic [1:0] c_st_locked   = 2'd2;

    // Synchroniser chains, one per pin; the MSB is the usable synced value
    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q,   lr_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;

    logic                bclk_prev_q, bclk_prev_d;
    logic                lr_prev_q,   lr_prev_d;
    logic [AUDIO_DW-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]    bitcnt_q,    bitcnt_d;
    logic [AUDIO_DW-1:0] left_hold_q, left_hold_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic [AUDIO_DW-1:0] left_out_q,  left_out_d;
    logic [AUDIO_DW-1:0] right_out_q, right_out_d;
    logic                valid_q,     valid_d;
    logic                overrun_q,   overrun_d;
    logic [1:0]          state_q,     state_d;

    logic                bclk_s, lr_s, data_s;
    logic                bit_evt, boundary, left_close, right_close;
    logic                slot_room, slot_full, timeout_hit, emit;
    logic [AUDIO_DW-1:0] slot_word;

    // Slot framing, capture, timeout counter and output handshake
    always_comb begin
        bclk_s      = bclk_sync_q[SYNC_STAGES-1];
        lr_s        = lr_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        bit_evt     = bclk_s & ~bclk_prev_q;
        boundary    = bit_evt & (lr_s ^ lr_prev_q);
        left_close  = boundary & lr_s;
        right_close = boundary & ~lr_s;
        slot_room   = (bitcnt_q < c_slot_bits);
        // The boundary bit still belongs to the closing slot, so one short is full
        slot_full   = (bitcnt_q >= c_slot_last);
        slot_word   = slot_room ? {shift_q[AUDIO_DW-2:0], data_s} : shift_q;
        emit        = right_close & slot_full & (state_q != c_st_unlocked);

        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i2s_data};
        bclk_prev_d = bclk_s;
        lr_prev_d   = lr_prev_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        left_hold_d = left_hold_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;

        if (bit_evt) begin
            lr_prev_d = lr_s;
            if (boundary) begin
                shift_d  = '0;
                bitcnt_d = '0;
                if (left_close && slot_full) begin
                    left_hold_d = slot_word;
                end
            end else if (slot_room) begin
                shift_d  = {shift_q[AUDIO_DW-2:0], data_s};
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end
        end

        if (bit_evt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == c_timeout) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        timeout_hit = (to_cnt_d == c_timeout);

        // A new frame wins over a pending one; overrun only if it was not taken
        if (emit) begin
            left_out_d  = left_hold_q;
            right_out_d = slot_word;
            valid_d     = 1'b1;
            overrun_d   = valid_q & ~sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // Lock FSM next-state: resync on a right-slot close, drop on short slot or idle bus
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                c_st_unlocked: if (right_close) state_d = c_st_sync;
                c_st_sync,
                c_st_locked: begin
                    if (!slot_full) begin
                        state_d = c_st_unlocked;
                    end else if (right_close) begin
                        state_d = c_st_locked;
                    end
                end
                default: state_d = c_st_unlocked;
            endcase
        end
        if (timeout_hit) begin
            state_d = c_st_unlocked;
        end
    end

    // Lock FSM outputs
    always_comb begin
        locked = (state_q == c_st_locked);
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_st_unlocked;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            data_sync_q <= '0;
            bclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            left_hold_q <= '0;
            to_cnt_q    <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            data_sync_q <= data_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            left_hold_q <= left_hold_d;
            to_cnt_q    <= to_cnt_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_audio_in
// Purpose  : Self-checking bench for i2s_audio_in. Drives I2S slots with
//            random content and compares emitted frames against a slot-level
//            lock/frame model.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_audio_in;

    localparam int DW   = 16;
    localparam int HALF = 5;    // clk cycles per bclk half period

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i2s_bclk = 1'b0;
    logic          i2s_lrclk = 1'b0;
    logic          i2s_data = 1'b0;
    logic          sample_ready = 1'b1;
    logic [DW-1:0] left_out, right_out;
    logic          sample_valid, locked, overrun;

    i2s_audio_in #(.AUDIO_DW(DW), .SYNC_STAGES(2), .TIMEOUT(1024)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .left_out    (left_out),
        .right_out   (right_out),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .locked      (locked),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- slot-level reference model ----------------
    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    frame_t        exp_q[$];
    int            m_st = 0;        // 0 unlocked, 1 sync, 2 locked
    logic          m_lr = 1'b0;     // lr of the slot currently being sent
    int            m_w = 0;         // its width in bits
    logic [31:0]   m_word = '0;
    logic [DW-1:0] m_left = '0;
    logic          prev_data = 1'b0; // LSB of the last slot, sent on the next boundary
    bit            head_sent = 1'b0;
    logic          head_lr = 1'b0;
    int            ovr_cnt = 0;

    function automatic logic [DW-1:0] top_bits(input int w, input logic [31:0] word);
        return DW'(word >> (w - DW));
    endfunction

    task automatic model_close(input logic closing_lr, input int w, input logic [31:0] word);
        bit full;
        full = (w >= DW);
        if (!closing_lr) begin
            if (full) m_left = top_bits(w, word);
            else if (m_st != 0) m_st = 0;
        end else begin
            if (m_st == 0) m_st = 1;
            else if (!full) m_st = 0;
            else begin
                exp_q.push_back({m_left, top_bits(w, word)});
                m_st = 2;
            end
        end
    endtask

    // ---------------- pin drivers ----------------
    task automatic send_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = d;
        repeat (HALF) @(posedge clk);
        #1 i2s_bclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input logic lr);
        if (lr != m_lr) begin
            model_close(m_lr, m_w, m_word);
            m_lr = lr;
        end
        send_bit(lr, prev_data);
        head_sent = 1'b1;
        head_lr   = lr;
    endtask

    task automatic send_slot(input logic lr, input int w, input logic [31:0] word);
        if (!(head_sent && head_lr == lr)) send_head(lr);
        head_sent = 1'b0;
        for (int i = w - 1; i >= 1; i--) send_bit(lr, word[i]);
        prev_data = word[0];
        m_w    = w;
        m_word = word;
    endtask

    task automatic send_frame(input int w, input logic [31:0] l, input logic [31:0] r);
        send_slot(1'b0, w, l);
        send_slot(1'b1, w, r);
    endtask

    // Boundary bit that closes the last right slot
    task automatic flush();
        send_head(1'b0);
    endtask

    task automatic drain(input string tag);
        repeat (30) @(posedge clk);
        #1;
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_lock"}, 32'(locked), 32'(m_st == 2));
    endtask

    function automatic int rand_width();
        int ws[3] = '{16, 24, 32};
        return ws[$urandom_range(2)];
    endfunction

    // Consumer: every accepted frame must be the next one the model expects
    always @(negedge clk) begin
        frame_t f;
        if (reset_n) begin
            if (overrun) ovr_cnt++;
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", 32'(sample_valid), 32'd0);
                end else begin
                    f = exp_q.pop_front();
                    check_eq("frame_left", 32'(left_out), 32'(f.l));
                    check_eq("frame_right", 32'(right_out), 32'(f.r));
                end
            end
        end
    end

    initial begin
        frame_t f2;
        int     w;

        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_left", 32'(left_out), 32'd0);
        check_eq("rst_right", 32'(right_out), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        // Nominal 64 bclk/frame with fixed corner values
        repeat (4) send_frame(32, 32'h8001_0000, 32'h7FFE_0000);
        flush();
        drain("nominal");
        check_eq("nominal_last_left", 32'(left_out), 32'h8001);
        check_eq("nominal_last_right", 32'(right_out), 32'h7FFE);

        // Random content and slot widths
        repeat (6) begin
            w = rand_width();
            send_frame(w, $urandom, $urandom);
        end
        flush();
        drain("random");

        // Wide slots: extra bits ignored
        send_frame(32, 32'hABCDEF12, 32'h00FF0000);
        flush();
        drain("wide");
        check_eq("wide_left", 32'(left_out), 32'hABCD);
        check_eq("wide_right", 32'(right_out), 32'h00FF);

        // Short slots drop lock, full slots regain it
        repeat (2) send_frame(12, $urandom, $urandom);
        flush();
        drain("short");
        check_eq("short_unlocked", 32'(locked), 32'd0);
        repeat (2) send_frame(32, $urandom, $urandom);
        flush();
        drain("relock");

        // Backpressure across two frames
        @(posedge clk);
        #1 sample_ready = 1'b0;
        send_frame(32, $urandom, $urandom);
        send_frame(32, $urandom, $urandom);
        flush();
        repeat (30) @(posedge clk);
        @(negedge clk);
        f2 = exp_q[exp_q.size() - 1];
        check_eq("bp_valid_held", 32'(sample_valid), 32'd1);
        check_eq("bp_left", 32'(left_out), 32'(f2.l));
        check_eq("bp_right", 32'(right_out), 32'(f2.r));
        check_eq("bp_overrun_cnt", 32'(ovr_cnt), 32'd1);
        void'(exp_q.pop_front());   // F1 was overwritten
        @(posedge clk);
        #1 sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_valid_drop", 32'(sample_valid), 32'd0);
        drain("backpressure");

        // Timeout: bus goes idle mid-frame
        send_frame(32, $urandom, $urandom);
        send_frame(32, $urandom, $urandom);
        repeat (900) @(posedge clk);
        #1 check_eq("to_still_locked", 32'(locked), 32'd1);
        repeat (200) @(posedge clk);
        #1 check_eq("to_unlocked", 32'(locked), 32'd0);
        m_st = 0;
        drain("timeout_idle");
        repeat (3) send_frame(32, $urandom, $urandom);
        flush();
        drain("timeout_restart");

        // Asynchronous reset in the middle of a right slot
        send_slot(1'b0, 32, $urandom);
        send_head(1'b1);
        repeat (5) send_bit(1'b1, 1'($urandom));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(sample_valid), 32'd0);
        check_eq("arst_locked", 32'(locked), 32'd0);
        check_eq("arst_left", 32'(left_out), 32'd0);
        check_eq("arst_right", 32'(right_out), 32'd0);
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_data  = 1'b0;
        m_st = 0; m_lr = 1'b0; m_w = 0; m_word = '0;
        prev_data = 1'b0; head_sent = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            w = rand_width();
            send_frame(w, $urandom, $urandom);
        end
        flush();
        drain("post_reset");
        check_eq("total_overruns", 32'(ovr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
